// File: rtl/mult_pkg.sv
// Shared types and elaboration-time helpers for the pipelined tree multiplier.
// The helpers size each adder-tree level and place it on the flat term bus.
package mult_pkg;

    typedef enum logic {
        MULT_UNSIGNED = 1'b0,
        MULT_SIGNED   = 1'b1
    } mult_mode_t;

    function automatic int calc_levels(input int size);
        int levels = 0;
        int span   = 1;
        while (span < size) begin
            span   = span * 2;
            levels = levels + 1;
        end
        return levels;
    endfunction

    function automatic int half_count(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int level_count(input int size, input int level);
        int n = size;
        for (int k = 0; k < level; k++) begin
            n = half_count(n);
        end
        return n;
    endfunction

    // Term index at which a level's operands start on the concatenated tree bus
    function automatic int level_offset(input int size, input int level);
        int off = 0;
        for (int k = 0; k < level; k++) begin
            off = off + level_count(size, k);
        end
        return off;
    endfunction

endpackage

// File: rtl/pipelined_tree_multiplier_if.sv
// Operand/result handshake bundle for the pipelined tree multiplier.
interface pipelined_tree_multiplier_if #(
    parameter int SIZE = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     a;
    logic [SIZE-1:0]     b;
    logic                op_signed;
    logic                out_valid;
    logic                out_ready;
    logic [2*SIZE-1:0]   c;
    logic                overflow;

    modport master (
        output in_valid, a, b, op_signed, out_ready,
        input  in_ready, out_valid, c, overflow
    );

    modport slave (
        input  in_valid, a, b, op_signed, out_ready,
        output in_ready, out_valid, c, overflow
    );
endinterface

// File: rtl/mult_tree_level.sv
// One registered level of the reduction tree: N terms in, ceil(N/2) terms out.
// Valid and mode ride along with the data and everything holds when advance=0.
module mult_tree_level
    import mult_pkg::*;
#(
    parameter int N     = 2,
    parameter int WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  advance,
    input  logic                                  in_valid,
    input  mult_mode_t                            in_mode,
    input  logic [N*WIDTH-1:0]                    in_terms,
    output logic                                  out_valid,
    output mult_mode_t                            out_mode,
    output logic [half_count(N)*WIDTH-1:0]        out_terms
);
    localparam int M     = half_count(N);
    localparam int PAIRS = N / 2;

    logic [M*WIDTH-1:0] sums;
    logic [M*WIDTH-1:0] terms_d, terms_q;
    logic               valid_d, valid_q;
    mult_mode_t         mode_d, mode_q;

    // Pairwise adders; carries out of WIDTH are dropped (modulo 2^WIDTH)
    for (genvar i = 0; i < PAIRS; i++) begin : g_pair
        assign sums[i*WIDTH +: WIDTH] = in_terms[2*i*WIDTH +: WIDTH]
                                      + in_terms[(2*i+1)*WIDTH +: WIDTH];
    end

    if (N % 2 == 1) begin : g_odd
        assign sums[(M-1)*WIDTH +: WIDTH] = in_terms[(N-1)*WIDTH +: WIDTH];
    end

    always_comb begin
        terms_d = terms_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        if (advance) begin
            terms_d = sums;
            valid_d = in_valid;
            mode_d  = in_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            terms_q <= '0;
            valid_q <= 1'b0;
            mode_q  <= MULT_UNSIGNED;
        end else begin
            terms_q <= terms_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
        end
    end

    assign out_terms = terms_q;
    assign out_valid = valid_q;
    assign out_mode  = mode_q;
endmodule

// File: rtl/pipelined_tree_multiplier.sv
// Pipelined multiply unit: registered partial products feed a registered adder tree.
// A single global stall (in_ready = !out_valid || out_ready) freezes every stage at once.
module pipelined_tree_multiplier
    import mult_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    pipelined_tree_multiplier_if.slave  bus
);
    localparam int LEVELS  = calc_levels(SIZE);
    localparam int W       = 2 * SIZE;
    localparam int TOTAL   = level_offset(SIZE, LEVELS + 1);
    localparam int OUT_OFF = level_offset(SIZE, LEVELS);

    logic               advance;
    logic [TOTAL*W-1:0] tree_terms;
    logic [LEVELS:0]    tree_valid;
    mult_mode_t         tree_mode [0:LEVELS];

    logic [SIZE*W-1:0]  pp_d, pp_q;
    logic               valid0_d, valid0_q;
    mult_mode_t         mode0_d, mode0_q;
    logic [W-1:0]       a_ext;
    logic [W-1:0]       term;
    logic [W-1:0]       product;
    logic [SIZE:0]      sign_field;

    assign advance      = !tree_valid[LEVELS] || bus.out_ready;
    assign bus.in_ready = advance;

    // In signed mode the MSB of b carries weight -2^(SIZE-1), so its row is negated
    always_comb begin
        pp_d     = pp_q;
        valid0_d = valid0_q;
        mode0_d  = mode0_q;
        a_ext    = bus.op_signed ? {{SIZE{bus.a[SIZE-1]}}, bus.a} : {{SIZE{1'b0}}, bus.a};
        term     = '0;
        if (advance) begin
            valid0_d = bus.in_valid;
            mode0_d  = bus.op_signed ? MULT_SIGNED : MULT_UNSIGNED;
            for (int i = 0; i < SIZE; i++) begin
                term = bus.b[i] ? (a_ext << i) : '0;
                if (i == SIZE - 1 && bus.op_signed) begin
                    term = -term;
                end
                pp_d[i*W +: W] = term;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_q     <= '0;
            valid0_q <= 1'b0;
            mode0_q  <= MULT_UNSIGNED;
        end else begin
            pp_q     <= pp_d;
            valid0_q <= valid0_d;
            mode0_q  <= mode0_d;
        end
    end

    assign tree_terms[0 +: SIZE*W] = pp_q;
    assign tree_valid[0]           = valid0_q;
    assign tree_mode[0]            = mode0_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int NIN     = level_count(SIZE, k);
        localparam int NOUT    = level_count(SIZE, k + 1);
        localparam int IN_OFF  = level_offset(SIZE, k);
        localparam int NXT_OFF = level_offset(SIZE, k + 1);

        mult_tree_level #(
            .N     (NIN),
            .WIDTH (W)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .in_valid  (tree_valid[k]),
            .in_mode   (tree_mode[k]),
            .in_terms  (tree_terms[IN_OFF*W +: NIN*W]),
            .out_valid (tree_valid[k+1]),
            .out_mode  (tree_mode[k+1]),
            .out_terms (tree_terms[NXT_OFF*W +: NOUT*W])
        );
    end

    // Overflow is decoded from the registered product and its travelling mode
    assign product       = tree_terms[OUT_OFF*W +: W];
    assign sign_field    = product[W-1:SIZE-1];
    assign bus.c         = product;
    assign bus.out_valid = tree_valid[LEVELS];
    assign bus.overflow  = (tree_mode[LEVELS] == MULT_SIGNED)
                         ? !((&sign_field) || !(|sign_field))
                         : (|product[W-1:SIZE]);
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Directed self-checking bench for the SIZE=8 pipelined tree multiplier.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_pipelined_tree_multiplier;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   out_idx;

    pipelined_tree_multiplier_if #(.SIZE(8)) bus ();

    pipelined_tree_multiplier #(.SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed vectors: back-to-back stream with alternating modes
    logic [7:0]  b2b_a   [6];
    logic [7:0]  b2b_b   [6];
    logic        b2b_m   [6];
    logic [15:0] b2b_c   [6];
    logic        b2b_o   [6];

    // Vectors used in the backpressure run
    logic [7:0]  bp_a    [3];
    logic [7:0]  bp_b    [3];
    logic        bp_m    [3];
    logic [15:0] bp_c    [3];
    logic        bp_o    [3];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic mode, input logic valid);
        bus.a         = av;
        bus.b         = bv;
        bus.op_signed = mode;
        bus.in_valid  = valid;
    endtask

    // One isolated transaction: accept, measure latency, compare result, let it drain
    task automatic singleCheck(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic mode, input logic [15:0] ec, input logic eo);
        int cycles;
        applyStimulus(av, bv, mode, 1'b1);
        #1;
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1'b1);
        @(negedge clk);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        cycles = 1;
        while (!bus.out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, 4);
        checkOutput({tag, "_c"}, bus.c, ec);
        checkOutput({tag, "_ovf"}, bus.overflow, eo);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        b2b_a = '{8'h03, 8'hFE, 8'h10, 8'h7F, 8'hC8, 8'hF0};
        b2b_b = '{8'h07, 8'h03, 8'h10, 8'h7F, 8'h01, 8'hF8};
        b2b_m = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        b2b_c = '{16'h0015, 16'hFFFA, 16'h0100, 16'h3F01, 16'h00C8, 16'h0080};
        b2b_o = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        bp_a  = '{8'h05, 8'hFF, 8'h20};
        bp_b  = '{8'h05, 8'hFF, 8'h08};
        bp_m  = '{1'b0,  1'b1,  1'b0};
        bp_c  = '{16'h0019, 16'h0001, 16'h0100};
        bp_o  = '{1'b0,  1'b0,  1'b1};

        rst           = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", bus.out_valid, 1'b0);
        checkOutput("reset_c", bus.c, 16'h0000);
        checkOutput("reset_ovf", bus.overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", bus.in_ready, 1'b1);

        singleCheck("u15x17",   8'd15, 8'd17, 1'b0, 16'h00FF, 1'b0);
        singleCheck("uFFxFF",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        singleCheck("s-3x5",    8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
        singleCheck("s80x80",   8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        singleCheck("s80x01",   8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0);

        out_idx = 0;
        for (int t = 0; t < 13; t++) begin
            if (t < 6) applyStimulus(b2b_a[t], b2b_b[t], b2b_m[t], 1'b1);
            else       applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("b2b_in_ready_t%0d", t), bus.in_ready, 1'b1);
            checkOutput($sformatf("b2b_out_valid_t%0d", t), bus.out_valid, (t >= 4 && t <= 9));
            if (bus.out_valid && out_idx < 6) begin
                checkOutput($sformatf("b2b_c_%0d", out_idx), bus.c, b2b_c[out_idx]);
                checkOutput($sformatf("b2b_ovf_%0d", out_idx), bus.overflow, b2b_o[out_idx]);
                out_idx++;
            end
            @(negedge clk);
        end
        checkOutput("b2b_result_count", out_idx, 6);

        out_idx = 0;
        for (int t = 0; t < 14; t++) begin
            if (t < 3) applyStimulus(bp_a[t], bp_b[t], bp_m[t], 1'b1);
            else       applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
            bus.out_ready = !(t >= 4 && t <= 8);
            #1;
            checkOutput($sformatf("bp_in_ready_t%0d", t), bus.in_ready, !(t >= 4 && t <= 8));
            checkOutput($sformatf("bp_out_valid_t%0d", t), bus.out_valid, (t >= 4 && t <= 11));
            if (bus.out_valid && out_idx < 3) begin
                checkOutput($sformatf("bp_c_t%0d", t), bus.c, bp_c[out_idx]);
                checkOutput($sformatf("bp_ovf_t%0d", t), bus.overflow, bp_o[out_idx]);
                if (bus.out_ready) out_idx++;
            end
            @(negedge clk);
        end
        checkOutput("bp_result_count", out_idx, 3);
        bus.out_ready = 1'b1;

        applyStimulus(8'h04, 8'h04, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(8'hFC, 8'h02, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(8'h09, 8'h09, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_out_valid", bus.out_valid, 1'b0);
        checkOutput("midreset_in_ready", bus.in_ready, 1'b1);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            checkOutput($sformatf("midreset_no_stale_t%0d", t), bus.out_valid, 1'b0);
        end
        singleCheck("fresh2x3", 8'd2, 8'd3, 1'b0, 16'h0006, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_tree_multiplier.md
Name: pipelined_tree_multiplier

Overview:
- Parametrised, pipelined successor to the combinational adder-tree multiplier.
- Forms SIZE shifted partial products, then reduces them pairwise through a registered adder tree. One pipeline register sits after partial-product generation and one after each tree level.
- Adds a per-transaction signed/unsigned mode, valid/ready handshakes on both sides with full-pipeline backpressure, and a mode-aware overflow flag.
- Sits in the ALU datapath as the multi-cycle MUL unit, issuing one multiply per cycle when not stalled.

Parameters:
- SIZE, 8, operand width in bits (>= 2).
- LEVELS, derived as ceil(log2(SIZE)), number of adder-tree levels; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  SIZE  multiplicand.
- b  input  SIZE  multiplier.
- op_signed  input  1  1 = two's-complement multiply, 0 = unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- c  output  2*SIZE  product.
- overflow  output  1  product does not fit in SIZE bits under the selected mode.

Behaviour:
- Reset: all stage valid bits are cleared. out_valid=0, c=0, overflow=0.
  - in_ready=1 in the cycle after reset is deasserted.
  - Reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Pipeline: stage 0 registers SIZE partial products. Stage k (1..LEVELS) registers the level-k pairwise sums.
  - Odd operand count at a level: the unpaired term passes through unchanged.
  - Latency L = LEVELS+1 cycles from accept to out_valid. SIZE=8 gives L=4; SIZE=16 gives L=5.
- Advance rule: advance = !out_valid || out_ready.
  - All stages shift together only when advance=1. Otherwise every stage holds.
  - in_ready = advance, combinational; this is the single global stall.
- Accept occurs when in_valid && in_ready. A stage whose valid bit is 0 carries a bubble. Bubbles advance normally and are not compressed.
- Throughput: one result per cycle with in_valid=1 and out_ready=1 held.
- Output stability: while out_valid=1 and out_ready=0, c and overflow hold stable.
- Arithmetic:
  - Operands are extended to 2*SIZE bits: sign-extended if op_signed=1, zero-extended if 0.
  - Partial product i = b_ext[i] ? (a_ext << i) : 0.
  - The MSB partial product is subtracted in signed mode, i.e. two's-complement negated before entering the tree.
  - All sums are modulo 2^(2*SIZE); internal adder carries are discarded.
- Mode travels with its data: op_signed is registered alongside each transaction, so mixed modes can be in flight together.
- Overflow:
  - Unsigned: overflow = |c[2*SIZE-1:SIZE].
  - Signed: overflow = 1 unless c[2*SIZE-1:SIZE-1] is all-zeros or all-ones.
- c and overflow are don't-care when out_valid=0, but must come from registers (no combinational path from a/b).
- Simultaneous accept and emit in the same cycle is legal and must lose nothing.

Decomposition:
- Package mult_pkg holds:
  - function calc_levels(size) returning ceil(log2(size));
  - localparam helper for the per-level operand count, ceil(n/2);
  - typedef enum logic {MULT_UNSIGNED, MULT_SIGNED} mult_mode_t.
- Sub-module mult_tree_level: one registered reduction level, parametrised by input count N and WIDTH.
  - Instantiates the existing adder per pair plus a pass-through for an odd leftover.
  - Carries valid and mode, and obeys the advance enable.
  - The top module generates LEVELS instances.

Test Plan (SIZE=8, L=4):
- Unsigned a=15, b=17, op_signed=0, out_ready=1 -> c=0x00FF, overflow=0; out_valid rises exactly 4 cycles after accept.
- Unsigned a=0xFF, b=0xFF -> c=0xFE01, overflow=1. Signed a=0xFD (-3), b=0x05 -> c=0xFFF1 (-15), overflow=0.
- Signed a=0x80, b=0x80 (-128*-128) -> c=0x4000, overflow=1. Signed a=0x80, b=0x01 -> c=0xFF80, overflow=0.
- Back-to-back: 6 consecutive accepts, alternating modes, out_ready=1 -> 6 consecutive out_valid cycles, results in order, in_ready never drops.
- Backpressure: 3 accepts, then out_ready=0 for 5 cycles once out_valid=1 -> in_ready=0 throughout, c held stable; after release the 3 results drain in order with no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle and no stale result ever appears. A fresh 2*3 then yields c=6 after 4 cycles.
